pong_game_ctrl: RTL and testbench
=================================

PONG_GAME_CTRL -- requirements
Module: pong_game_ctrl

Interface
REQ-001 Parameter NUM_BALLS, default 3, balls per game, legal range 1..3.
REQ-002 Parameter TIMER_TICKS, default 120, frame ticks in the pause timer (2 s at 60 Hz), legal range 1..127.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 refr_tick  input  1  one-cycle pulse, once per video frame.
REQ-006 btn  input  2  paddle buttons, level, already debounced; "any button" means btn != 2'b00.
REQ-007 hit  input  1  one-cycle pulse, ball struck paddle.
REQ-008 miss  input  1  one-cycle pulse, ball passed paddle.
REQ-009 gra_still  output  1  high freezes ball/paddle animation at start position.
REQ-010 dig0  output  4  score units digit, BCD.
REQ-011 dig1  output  4  score tens digit, BCD.
REQ-012 balls_left  output  2  remaining spare balls.
REQ-013 game_state  output  2  current state encoding.
REQ-014 game_over  output  1  high while in OVER.

Function
REQ-015 FSM states, encoding: NEWGAME=00, PLAY=01, NEWBALL=10, OVER=11; all outputs registered or decoded directly from registered state.
REQ-016 NEWGAME: gra_still=1; any button -> PLAY next cycle, same edge clears dig1/dig0 to 0/0 and loads balls_left with NUM_BALLS-1.
REQ-017 PLAY: gra_still=0; hit increments score one cycle later; miss with balls_left!=0 -> NEWBALL, balls_left decremented on same edge; miss with balls_left==0 -> OVER.
REQ-018 Score is 2-digit BCD: units 9 -> 0 with tens +1; 99 + hit wraps to 00; no non-BCD value ever output.
REQ-019 hit and miss asserted in the same PLAY cycle: miss wins, score unchanged.
REQ-020 hit or miss outside PLAY ignored.
REQ-021 Pause timer: 7-bit down counter loaded with TIMER_TICKS on every transition into NEWBALL or OVER; decrements by 1 on each refr_tick while nonzero; timer_up = (count == 0).
REQ-022 NEWBALL: gra_still=1; timer_up and any button -> PLAY; button before timer_up has no effect; button held through timer_up transitions on first cycle timer_up is true.
REQ-023 OVER: gra_still=1, game_over=1; timer_up -> NEWGAME regardless of buttons; score held for display through OVER and NEWGAME until next game start.
REQ-024 refr_tick coincident with a state-entry load: load wins, no decrement that cycle.
REQ-025 No illegal states exist with 2-bit encoding; no default recovery needed beyond full decode.

Reset
REQ-026 reset high at rising edge forces, on that edge: state=NEWGAME, dig1=dig0=0, balls_left=NUM_BALLS-1, timer=0, gra_still=1, game_over=0.
REQ-027 reset has priority over every other input, including mid-PLAY and mid-timer; hit/miss in the reset cycle are discarded.

Structure
REQ-028 Shared package pong_pkg holds state encoding constants, default NUM_BALLS, default TIMER_TICKS, and frame rate constant 60.
REQ-029 Pause timer is a separate sub-module pong_timer (ports clk, reset, tick, load, timer_up); BCD counter and FSM stay in pong_game_ctrl.

Verification
REQ-030 Reset then btn=01 one cycle -> game_state 00->01 next edge, gra_still 0, balls_left=2, dig1/dig0=0/0.
REQ-031 In PLAY, 100 hit pulses -> score reads 09->10 at 10th, 99 at 99th, 00 at 100th; never non-BCD.
REQ-032 In PLAY, hit and miss same cycle with balls_left=2 -> NEWBALL, balls_left=1, score unchanged.
REQ-033 In NEWBALL, btn held, 119 refr_tick -> stays NEWBALL; 120th tick -> timer_up, PLAY one cycle later.
REQ-034 Miss with balls_left=0 -> OVER, game_over=1; 120 refr_tick, no button -> NEWGAME, score retained until next button.
REQ-035 reset asserted mid-NEWBALL with timer=57 -> next edge all outputs at REQ-026 values.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared constants, state encoding and score type for the pong game controller.
package pong_pkg;

  localparam int unsigned STATE_W             = 2;
  localparam int unsigned BCD_W               = 4;
  localparam int unsigned BALLS_W             = 2;
  localparam int unsigned TIMER_W             = 7;
  localparam int unsigned DEFAULT_NUM_BALLS   = 3;
  localparam int unsigned DEFAULT_TIMER_TICKS = 120;
  localparam int unsigned FRAME_RATE          = 60;

  typedef enum logic [STATE_W-1:0] {
    ST_NEWGAME = 2'b00,
    ST_PLAY    = 2'b01,
    ST_NEWBALL = 2'b10,
    ST_OVER    = 2'b11
  } game_state_t;

  typedef struct packed {
    logic [BCD_W-1:0] tens;
    logic [BCD_W-1:0] units;
  } score_t;

  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  // Two-digit BCD increment, 99 wraps to 00.
  function automatic score_t bcd_inc(input score_t s);
    score_t r;
    r = s;
    if (s.units == BCD_MAX) begin
      r.units = '0;
      r.tens  = (s.tens == BCD_MAX) ? '0 : s.tens + BCD_W'(1);
    end else begin
      r.units = s.units + BCD_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/pong_timer.sv
// Frame-tick pause timer: loads on request, counts refresh ticks down to zero.
module pong_timer
  import pong_pkg::*;
#(
  parameter int unsigned TIMER_TICKS = DEFAULT_TIMER_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic load,
  output logic timer_up
);

  logic [TIMER_W-1:0] count;

  // Load takes priority over a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= TIMER_W'(TIMER_TICKS);
    end else if (tick && (count != '0)) begin
      count <= count - TIMER_W'(1);
    end
  end

  assign timer_up = (count == '0);

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game flow controller: game FSM, two-digit BCD score and spare-ball count.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int unsigned NUM_BALLS   = DEFAULT_NUM_BALLS,
  parameter int unsigned TIMER_TICKS = DEFAULT_TIMER_TICKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               refr_tick,
  input  logic [1:0]         btn,
  input  logic               hit,
  input  logic               miss,
  output logic               gra_still,
  output logic [BCD_W-1:0]   dig0,
  output logic [BCD_W-1:0]   dig1,
  output logic [BALLS_W-1:0] balls_left,
  output logic [STATE_W-1:0] game_state,
  output logic               game_over
);

  localparam logic [BALLS_W-1:0] BALLS_INIT = BALLS_W'(NUM_BALLS - 1);

  game_state_t        state, state_next;
  score_t             score;
  logic [BALLS_W-1:0] balls_q;
  logic               any_btn;
  logic               timer_up;
  logic               timer_load;
  logic               start_game;
  logic               score_inc;
  logic               ball_lost;

  assign any_btn = (btn != 2'b00);

  pong_timer #(
    .TIMER_TICKS(TIMER_TICKS)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .tick    (refr_tick),
    .load    (timer_load),
    .timer_up(timer_up)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_NEWGAME;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus datapath strobes; a miss in PLAY beats a coincident hit.
  always_comb begin
    state_next = state;
    timer_load = 1'b0;
    start_game = 1'b0;
    score_inc  = 1'b0;
    ball_lost  = 1'b0;
    case (state)
      ST_NEWGAME: begin
        if (any_btn) begin
          state_next = ST_PLAY;
          start_game = 1'b1;
        end
      end
      ST_PLAY: begin
        if (miss) begin
          timer_load = 1'b1;
          if (balls_q != '0) begin
            state_next = ST_NEWBALL;
            ball_lost  = 1'b1;
          end else begin
            state_next = ST_OVER;
          end
        end else if (hit) begin
          score_inc = 1'b1;
        end
      end
      ST_NEWBALL: begin
        if (timer_up && any_btn) begin
          state_next = ST_PLAY;
        end
      end
      ST_OVER: begin
        if (timer_up) begin
          state_next = ST_NEWGAME;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      score <= '0;
    end else if (start_game) begin
      score <= '0;
    end else if (score_inc) begin
      score <= bcd_inc(score);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      balls_q <= BALLS_INIT;
    end else if (start_game) begin
      balls_q <= BALLS_INIT;
    end else if (ball_lost) begin
      balls_q <= balls_q - BALLS_W'(1);
    end
  end

  assign dig0       = score.units;
  assign dig1       = score.tens;
  assign balls_left = balls_q;
  assign game_state = state;
  assign gra_still  = (state != ST_PLAY);
  assign game_over  = (state == ST_OVER);

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl against a cycle-level behavioural model.
module tb_pong_game_ctrl;

  localparam int NB = 3;
  localparam int TT = 120;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refr_tick = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic       gra_still;
  logic [3:0] dig0;
  logic [3:0] dig1;
  logic [1:0] balls_left;
  logic [1:0] game_state;
  logic       game_over;

  pong_game_ctrl #(
    .NUM_BALLS  (NB),
    .TIMER_TICKS(TT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .refr_tick (refr_tick),
    .btn       (btn),
    .hit       (hit),
    .miss      (miss),
    .gra_still (gra_still),
    .dig0      (dig0),
    .dig1      (dig1),
    .balls_left(balls_left),
    .game_state(game_state),
    .game_over (game_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] st;
    logic [3:0] d1;
    logic [3:0] d0;
    logic [1:0] bl;
    logic       gs;
    logic       go;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int m_state = 0;
  int m_score = 0;
  int m_balls = NB - 1;
  int m_timer = 0;

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  // Drive one cycle, advance the model, push its prediction, then compare after the edge.
  task automatic step(input bit rst, input logic [1:0] b, input bit h, input bit m, input bit t);
    int   ns;
    bit   tup;
    exp_t e;
    @(negedge clk);
    reset = rst; btn = b; hit = h; miss = m; refr_tick = t;
    tup = (m_timer == 0);
    if (rst) begin
      m_state = 0; m_score = 0; m_balls = NB - 1; m_timer = 0;
    end else begin
      ns = m_state;
      case (m_state)
        0: if (b != 0) begin ns = 1; m_score = 0; m_balls = NB - 1; end
        1: begin
          if (m) begin
            if (m_balls > 0) begin ns = 2; m_balls--; end
            else ns = 3;
          end else if (h) begin
            m_score = (m_score + 1) % 100;
          end
        end
        2: if (tup && b != 0) ns = 1;
        default: if (tup) ns = 0;
      endcase
      if (ns != m_state && (ns == 2 || ns == 3)) m_timer = TT;
      else if (t && m_timer > 0) m_timer--;
      m_state = ns;
    end
    e.st = 2'(m_state);
    e.d1 = 4'(m_score / 10);
    e.d0 = 4'(m_score % 10);
    e.bl = 2'(m_balls);
    e.gs = (m_state != 1);
    e.go = (m_state == 3);
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("sb_empty", 0, 1);
    end else begin
      e = q.pop_front();
      check("game_state", game_state, e.st);
      check("dig1", dig1, e.d1);
      check("dig0", dig0, e.d0);
      check("balls_left", balls_left, e.bl);
      check("gra_still", gra_still, e.gs);
      check("game_over", game_over, e.go);
    end
  endtask

  initial begin
    step(1, 2'b00, 0, 0, 0);
    step(1, 2'b00, 0, 0, 0);
    check("rst_state", game_state, 0);
    check("rst_still", gra_still, 1);
    check("rst_balls", balls_left, 2);
    check("rst_over", game_over, 0);

    // hit/miss ignored outside PLAY
    step(0, 2'b00, 1, 0, 1);
    step(0, 2'b00, 0, 1, 0);
    step(0, 2'b01, 0, 0, 0);
    check("start_state", game_state, 1);
    check("start_still", gra_still, 0);
    check("start_balls", balls_left, 2);

    for (int i = 1; i <= 100; i++) begin
      step(0, 2'b00, 1, 0, 1'($urandom_range(0, 1)));
      if (i == 9)   check("hit9", {dig1, dig0}, 8'h09);
      if (i == 10)  check("hit10", {dig1, dig0}, 8'h10);
      if (i == 99)  check("hit99", {dig1, dig0}, 8'h99);
      if (i == 100) check("hit100", {dig1, dig0}, 8'h00);
    end
    for (int i = 0; i < 3; i++) step(0, 2'b00, 1, 0, 0);

    // hit and miss together, with a tick coinciding with the timer load
    step(0, 2'b00, 1, 1, 1);
    check("hm_state", game_state, 2);
    check("hm_balls", balls_left, 1);
    check("hm_score", {dig1, dig0}, 8'h03);

    for (int i = 1; i <= TT; i++) begin
      step(0, 2'b10, 0, 0, 1);
      if (i == TT - 1) check("nb_119", game_state, 2);
      if (i == TT)     check("nb_120", game_state, 2);
    end
    step(0, 2'b10, 0, 0, 0);
    check("nb_resume", game_state, 1);

    // lose the last spare, then the final ball
    step(0, 2'b00, 0, 1, 0);
    for (int i = 0; i < TT + 1; i++) step(0, 2'b01, 0, 0, 1);
    check("nb2_resume", game_state, 1);
    check("nb2_balls", balls_left, 0);
    step(0, 2'b00, 0, 1, 0);
    check("over_state", game_state, 3);
    check("over_flag", game_over, 1);
    for (int i = 0; i < TT; i++) step(0, 2'b00, 1, 0, 1);
    step(0, 2'b00, 0, 0, 0);
    check("over_done", game_state, 0);
    check("over_score", {dig1, dig0}, 8'h03);
    step(0, 2'b00, 0, 0, 1);
    check("ng_score", {dig1, dig0}, 8'h03);

    // new game, then reset mid-NEWBALL with timer at 57
    step(0, 2'b11, 0, 0, 0);
    check("ng2_score", {dig1, dig0}, 8'h00);
    for (int i = 0; i < 5; i++) step(0, 2'b00, 1, 0, 0);
    step(0, 2'b00, 0, 1, 0);
    for (int i = 0; i < TT - 57; i++) step(0, 2'b00, 0, 0, 1);
    check("pre_rst_timer", m_timer, 57);
    step(1, 2'b01, 1, 1, 1);
    check("mrst_state", game_state, 0);
    check("mrst_score", {dig1, dig0}, 8'h00);
    check("mrst_balls", balls_left, 2);
    check("mrst_still", gra_still, 1);
    check("mrst_over", game_over, 0);
    step(0, 2'b00, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
